mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports, one per line: name direction width meaning.
  CLK  in  1  clock, rising edge
  nRST  in  1  asynchronous active-low reset
  ex_valid  in  1  EX/MEM entry offered
  ex_ready  out  1  entry accepted this cycle when ex_valid&&ex_ready
  ex_MemRead, ex_MemWrite  in  1 each  load / store
  ex_datomic  in  1  LL (with MemRead) or SC (with MemWrite)
  ex_addr, ex_store, ex_pc_4, ex_alu_out, ex_wsel  in  32 each  EX/MEM payload
  ex_RegWr, ex_halt  in  1 each  control
  ex_MemtoReg  in  2  writeback select
  flush  in  1  discard held entry
  dmemREN, dmemWEN  out  1 each  data-cache request
  dmemaddr, dmemstore  out  32 each  request address / data
  dmemload  in  32  read data
  dhit  in  1  request complete this cycle
  ccinv  in  1  coherence invalidate strobe
  ccsnoopaddr  in  32  invalidated address
  mem_pc_4, mem_dmemload, mem_alu_out, mem_wsel  out  32 each  MEM/WB payload
  mem_RegWr, mem_halt  out  1 each  MEM/WB control
  mem_MemtoReg  out  2  MEM/WB writeback select
  memwb_EN  out  1  MEM/WB register load strobe
  memwb_flush  out  1  MEM/WB register clear strobe
REQ-002 SHALL use CLK as its only clock and nRST as an asynchronous, active-low reset.

Function
REQ-003 SHALL hold one entry in registers; states EMPTY, HOLD_ALU (no memory op), HOLD_MEM (load/store pending), HALTED.
REQ-004 SHALL assert ex_ready = (state==EMPTY) || (memwb_EN && !mem_halt); it SHALL be 0 in HALTED and whenever flush=1.
REQ-005 On accept, SHALL capture all ex_* payload; next state HOLD_MEM if MemRead||MemWrite, else HOLD_ALU.
REQ-006 mem_* outputs SHALL be driven from held registers; mem_dmemload SHALL pass dmemload through combinationally.
REQ-007 HOLD_ALU: memwb_EN=1 in the first held cycle (one-cycle latency accept->MEM/WB load).
REQ-008 HOLD_MEM: dmemREN/dmemWEN = held MemRead/MemWrite; dmemaddr=held addr; dmemstore=held store; held until dhit; memwb_EN=1 only in the dhit cycle; REN/WEN SHALL never both be 1.
REQ-009 Outside HOLD_MEM, dmemREN=dmemWEN=0, and dmemaddr/dmemstore SHALL hold their last values.
REQ-010 Completion with accept in the same cycle SHALL load the new entry back-to-back with no bubble.
REQ-011 Completion of an entry with mem_halt=1 SHALL go to HALTED; HALTED exits only by reset.
REQ-012 flush in EMPTY/HOLD_ALU: next state EMPTY, memwb_EN=0, memwb_flush=1.
REQ-013 flush in HOLD_MEM: request SHALL stay asserted until dhit (the cache cannot abort); the dhit cycle gives memwb_EN=0, memwb_flush=1, then EMPTY; the entry is marked dropped, so later flush pulses change nothing.
REQ-014 ex_valid in the same cycle as flush SHALL be ignored.

Reset
REQ-015 While nRST=0: state EMPTY, all held registers and all outputs 0, ex_ready=1 after release, link register invalid.

Configuration
REQ-016 Macro LL_SC_EN. Defined: LL loads and sets link={valid, addr}. SC with valid link and equal addr issues a store and completes with mem_alu_out=1; otherwise no request, completes in the first held cycle with mem_alu_out=0. Any SC, any local store to the link addr, or ccinv with ccsnoopaddr==link addr clears link. ccinv and SC in the same cycle: invalidate wins.
REQ-017 Undefined: ex_datomic, ccinv and ccsnoopaddr SHALL be ignored (ports kept); LL behaves as load, SC as store.

Verification
REQ-018 Reset mid-HOLD_MEM (REN=1) -> REN=0, EMPTY, all outputs 0 immediately.
REQ-019 Load addr 0x100, dhit after 3 cycles with dmemload 0xDEADBEEF -> REN=1 for 3 cycles, memwb_EN=1 only in the dhit cycle, mem_dmemload=0xDEADBEEF.
REQ-020 Three back-to-back ALU entries -> memwb_EN=1 for 3 consecutive cycles, ex_ready stays 1.
REQ-021 Flush during a pending store -> WEN held until dhit, memwb_EN=0, memwb_flush=1 in the dhit cycle.
REQ-022 Halt entry -> one memwb_EN with mem_halt=1, then ex_ready=0 indefinitely.
REQ-023 LL_SC_EN defined: LL 0x200, ccinv at 0x200, SC 0x200 -> no WEN, mem_alu_out=0; repeat without ccinv -> WEN, mem_alu_out=1.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// EX/MEM entry, data-cache request and MEM/WB result bundle for mem_access_unit.
// Latency: none (wires only); the slave modport is the memory stage, the master the surrounding pipeline.
// Backpressure: ex_valid/ex_ready handshake on the entry side; the data cache holds off via dhit.
interface mem_access_unit_if;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_MemRead;
    logic        ex_MemWrite;
    logic        ex_datomic;
    logic [31:0] ex_addr;
    logic [31:0] ex_store;
    logic [31:0] ex_pc_4;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_wsel;
    logic        ex_RegWr;
    logic        ex_halt;
    logic [1:0]  ex_MemtoReg;
    logic        flush;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic [31:0] dmemload;
    logic        dhit;
    logic        ccinv;
    logic [31:0] ccsnoopaddr;
    logic [31:0] mem_pc_4;
    logic [31:0] mem_dmemload;
    logic [31:0] mem_alu_out;
    logic [31:0] mem_wsel;
    logic        mem_RegWr;
    logic        mem_halt;
    logic [1:0]  mem_MemtoReg;
    logic        memwb_EN;
    logic        memwb_flush;

    modport slave (
        input  ex_valid, ex_MemRead, ex_MemWrite, ex_datomic,
        input  ex_addr, ex_store, ex_pc_4, ex_alu_out, ex_wsel,
        input  ex_RegWr, ex_halt, ex_MemtoReg, flush,
        input  dmemload, dhit, ccinv, ccsnoopaddr,
        output ex_ready, dmemREN, dmemWEN, dmemaddr, dmemstore,
        output mem_pc_4, mem_dmemload, mem_alu_out, mem_wsel,
        output mem_RegWr, mem_halt, mem_MemtoReg, memwb_EN, memwb_flush
    );

    modport master (
        output ex_valid, ex_MemRead, ex_MemWrite, ex_datomic,
        output ex_addr, ex_store, ex_pc_4, ex_alu_out, ex_wsel,
        output ex_RegWr, ex_halt, ex_MemtoReg, flush,
        output dmemload, dhit, ccinv, ccsnoopaddr,
        input  ex_ready, dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  mem_pc_4, mem_dmemload, mem_alu_out, mem_wsel,
        input  mem_RegWr, mem_halt, mem_MemtoReg, memwb_EN, memwb_flush
    );
endinterface

// File: rtl/mem_access_unit.sv
// Single-entry memory stage: holds one EX/MEM entry, issues its data-cache access, strobes MEM/WB.
// Latency: ALU entries load MEM/WB one cycle after accept; memory entries in the dhit cycle.
// Backpressure: ex_ready only while empty or completing (not on halt/flush); LL/SC link tracking under `LL_SC_EN.
module mem_access_unit (
    input  logic             CLK,
    input  logic             nRST,
    mem_access_unit_if.slave bus
);
    localparam logic [1:0] EMPTY    = 2'd0;
    localparam logic [1:0] HOLD_ALU = 2'd1;
    localparam logic [1:0] HOLD_MEM = 2'd2;
    localparam logic [1:0] HALTED   = 2'd3;

    logic [1:0]  state, state_d;
    logic        rd_q, wr_q, regwr_q, halt_q, dropped_q;
    logic [1:0]  m2r_q;
    logic [31:0] addr_q, store_q, pc_4_q, alu_q, wsel_q;
    logic [31:0] last_addr_q, last_store_q;
    logic        in_mem, req_rd, req_wr, req, done, complete, accept;
    logic        wb_en, sc_fail;

`ifdef LL_SC_EN
    logic        sc_q, sc_ok_q;
    logic        link_vld_q;
    logic [31:0] link_addr_q;
    logic        snoop_hit;

    assign snoop_hit = bus.ccinv && link_vld_q && (bus.ccsnoopaddr == link_addr_q);
    assign sc_fail   = sc_q && !sc_ok_q;
`else
    logic unused_atomic;

    // Atomic and coherence inputs have no effect in this build.
    assign unused_atomic = ^{bus.ex_datomic, bus.ccinv, bus.ccsnoopaddr};
    assign sc_fail       = 1'b0;
`endif

    assign in_mem   = (state == HOLD_MEM);
    assign req_rd   = in_mem && rd_q;
    assign req_wr   = in_mem && wr_q && !sc_fail;
    assign req      = req_rd || req_wr;
    // A failed SC has nothing to wait for and finishes in its first held cycle.
    assign done     = in_mem && (!req || bus.dhit);
    assign complete = (state == HOLD_ALU) || done;
    assign wb_en    = complete && !bus.flush && !dropped_q;
    assign accept   = bus.ex_valid && bus.ex_ready;

    assign bus.ex_ready     = nRST && !bus.flush &&
                              ((state == EMPTY) || (wb_en && !halt_q));
    assign bus.memwb_EN     = wb_en;
    assign bus.memwb_flush  = nRST && ((bus.flush && (state == EMPTY || state == HOLD_ALU)) ||
                                       (done && (bus.flush || dropped_q)));
    assign bus.dmemREN      = req_rd;
    assign bus.dmemWEN      = req_wr;
    assign bus.dmemaddr     = req ? addr_q  : last_addr_q;
    assign bus.dmemstore    = req ? store_q : last_store_q;
    assign bus.mem_pc_4     = pc_4_q;
    assign bus.mem_wsel     = wsel_q;
    assign bus.mem_RegWr    = regwr_q;
    assign bus.mem_halt     = halt_q;
    assign bus.mem_MemtoReg = m2r_q;
    assign bus.mem_dmemload = nRST ? bus.dmemload : 32'd0;
`ifdef LL_SC_EN
    assign bus.mem_alu_out  = sc_q ? {31'd0, sc_ok_q} : alu_q;
`else
    assign bus.mem_alu_out  = alu_q;
`endif

    // Next state: completion empties (or halts), a same-cycle accept refills with no bubble.
    always_comb begin
        state_d = state;
        case (state)
            EMPTY:    state_d = EMPTY;
            HOLD_ALU,
            HOLD_MEM: if (complete) state_d = (wb_en && halt_q) ? HALTED : EMPTY;
            default:  state_d = HALTED;
        endcase
        if (accept)
            state_d = (bus.ex_MemRead || bus.ex_MemWrite) ? HOLD_MEM : HOLD_ALU;
    end

    // State register and the dropped marker for entries flushed while their access is in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= EMPTY;
            dropped_q <= 1'b0;
        end else begin
            state <= state_d;
            if (accept || complete)
                dropped_q <= 1'b0;
            else if (bus.flush && in_mem)
                dropped_q <= 1'b1;
        end
    end

    // Capture the whole entry on accept; a read wins if both read and write are offered.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            pc_4_q  <= '0;
            alu_q   <= '0;
            wsel_q  <= '0;
            regwr_q <= 1'b0;
            halt_q  <= 1'b0;
            m2r_q   <= '0;
        end else if (accept) begin
            rd_q    <= bus.ex_MemRead;
            wr_q    <= bus.ex_MemWrite && !bus.ex_MemRead;
            addr_q  <= bus.ex_addr;
            store_q <= bus.ex_store;
            pc_4_q  <= bus.ex_pc_4;
            alu_q   <= bus.ex_alu_out;
            wsel_q  <= bus.ex_wsel;
            regwr_q <= bus.ex_RegWr;
            halt_q  <= bus.ex_halt;
            m2r_q   <= bus.ex_MemtoReg;
        end
    end

    // Remember the last driven request so address/data stay stable between accesses.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_addr_q  <= '0;
            last_store_q <= '0;
        end else if (req) begin
            last_addr_q  <= addr_q;
            last_store_q <= store_q;
        end
    end

`ifdef LL_SC_EN
    // Link register: LL sets it; SC, a local store to the linked word or a matching snoop clear it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_vld_q  <= 1'b0;
            link_addr_q <= '0;
            sc_q        <= 1'b0;
            sc_ok_q     <= 1'b0;
        end else begin
            if (accept) begin
                sc_q    <= bus.ex_datomic && bus.ex_MemWrite && !bus.ex_MemRead;
                sc_ok_q <= bus.ex_datomic && bus.ex_MemWrite && !bus.ex_MemRead &&
                           link_vld_q && (link_addr_q == bus.ex_addr) && !snoop_hit;
            end
            if (accept && bus.ex_datomic && bus.ex_MemRead) begin
                link_vld_q  <= !(bus.ccinv && (bus.ccsnoopaddr == bus.ex_addr));
                link_addr_q <= bus.ex_addr;
            end else if (snoop_hit) begin
                link_vld_q <= 1'b0;
            end else if (accept && bus.ex_MemWrite &&
                         (bus.ex_datomic || bus.ex_addr == link_addr_q)) begin
                link_vld_q <= 1'b0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, ALU streaming, flush, reset, LL/SC and halt.
// Latency: inputs change 1ns after a rising edge, outputs are compared 2ns later.
// Backpressure: dhit and flush are driven by the vectors below.
module tb_mem_access_unit;
    logic CLK;
    logic nRST;
    int   n_checks;
    int   n_fail;

    mem_access_unit_if bus();

    mem_access_unit dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.ex_valid    = 1'b0;
        bus.ex_MemRead  = 1'b0;
        bus.ex_MemWrite = 1'b0;
        bus.ex_datomic  = 1'b0;
        bus.ex_halt     = 1'b0;
    endtask

    task automatic offer(input logic rd, input logic wr, input logic atomic, input logic [31:0] addr,
                         input logic [31:0] store, input logic [31:0] alu, input logic halt);
        bus.ex_valid    = 1'b1;
        bus.ex_MemRead  = rd;
        bus.ex_MemWrite = wr;
        bus.ex_datomic  = atomic;
        bus.ex_addr     = addr;
        bus.ex_store    = store;
        bus.ex_alu_out  = alu;
        bus.ex_pc_4     = addr + 32'd4;
        bus.ex_wsel     = 32'd7;
        bus.ex_RegWr    = 1'b1;
        bus.ex_MemtoReg = 2'd1;
        bus.ex_halt     = halt;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nRST     = 1'b0;
        idle();
        bus.ex_addr = '0; bus.ex_store = '0; bus.ex_pc_4 = '0; bus.ex_alu_out = '0;
        bus.ex_wsel = '0; bus.ex_RegWr = 1'b0; bus.ex_MemtoReg = '0;
        bus.flush = 1'b0; bus.dmemload = 32'h0; bus.dhit = 1'b0;
        bus.ccinv = 1'b0; bus.ccsnoopaddr = '0;

        // Reset state
        #2;
        check("rst_ready", {31'd0, bus.ex_ready}, 32'd0);
        check("rst_wb_en", {31'd0, bus.memwb_EN}, 32'd0);
        check("rst_ren", {31'd0, bus.dmemREN}, 32'd0);
        check("rst_alu", bus.mem_alu_out, 32'd0);
        cyc(); cyc();
        nRST = 1'b1;
        #2;
        check("post_rst_ready", {31'd0, bus.ex_ready}, 32'd1);

        // Load 0x100, dhit on the third request cycle
        offer(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0);
        #1;
        check("ld_ready", {31'd0, bus.ex_ready}, 32'd1);
        cyc(); idle(); #2;
        check("ld_ren_c1", {31'd0, bus.dmemREN}, 32'd1);
        check("ld_addr", bus.dmemaddr, 32'h100);
        check("ld_wb_c1", {31'd0, bus.memwb_EN}, 32'd0);
        cyc(); #2;
        check("ld_ren_c2", {31'd0, bus.dmemREN}, 32'd1);
        check("ld_wb_c2", {31'd0, bus.memwb_EN}, 32'd0);
        cyc(); bus.dhit = 1'b1; bus.dmemload = 32'hDEADBEEF; #2;
        check("ld_ren_c3", {31'd0, bus.dmemREN}, 32'd1);
        check("ld_wen_c3", {31'd0, bus.dmemWEN}, 32'd0);
        check("ld_wb_c3", {31'd0, bus.memwb_EN}, 32'd1);
        check("ld_data", bus.mem_dmemload, 32'hDEADBEEF);
        check("ld_wsel", bus.mem_wsel, 32'd7);
        check("ld_pc4", bus.mem_pc_4, 32'h104);
        cyc(); bus.dhit = 1'b0; #2;
        check("ld_ren_after", {31'd0, bus.dmemREN}, 32'd0);
        check("ld_wb_after", {31'd0, bus.memwb_EN}, 32'd0);
        check("ld_addr_hold", bus.dmemaddr, 32'h100);

        // Three back-to-back ALU entries
        offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h11, 1'b0); #2;
        check("alu_wb_0", {31'd0, bus.memwb_EN}, 32'd0);
        cyc(); offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h22, 1'b0); #2;
        check("alu_wb_1", {31'd0, bus.memwb_EN}, 32'd1);
        check("alu_val_1", bus.mem_alu_out, 32'h11);
        check("alu_rdy_1", {31'd0, bus.ex_ready}, 32'd1);
        cyc(); offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h33, 1'b0); #2;
        check("alu_wb_2", {31'd0, bus.memwb_EN}, 32'd1);
        check("alu_val_2", bus.mem_alu_out, 32'h22);
        check("alu_rdy_2", {31'd0, bus.ex_ready}, 32'd1);
        cyc(); idle(); #2;
        check("alu_wb_3", {31'd0, bus.memwb_EN}, 32'd1);
        check("alu_val_3", bus.mem_alu_out, 32'h33);
        cyc(); #2;
        check("alu_wb_end", {31'd0, bus.memwb_EN}, 32'd0);

        // Flush during a pending store, then a second flush pulse
        offer(1'b0, 1'b1, 1'b0, 32'h300, 32'hCAFE0001, 32'h0, 1'b0);
        cyc(); idle(); bus.flush = 1'b1; #2;
        check("st_wen_flush", {31'd0, bus.dmemWEN}, 32'd1);
        check("st_data", bus.dmemstore, 32'hCAFE0001);
        check("st_rdy_flush", {31'd0, bus.ex_ready}, 32'd0);
        check("st_mwf_early", {31'd0, bus.memwb_flush}, 32'd0);
        cyc(); bus.flush = 1'b0; #2;
        check("st_wen_held", {31'd0, bus.dmemWEN}, 32'd1);
        cyc(); bus.flush = 1'b1; #2;
        cyc(); bus.flush = 1'b0; bus.dhit = 1'b1; #2;
        check("st_wen_dhit", {31'd0, bus.dmemWEN}, 32'd1);
        check("st_wb_dhit", {31'd0, bus.memwb_EN}, 32'd0);
        check("st_mwf_dhit", {31'd0, bus.memwb_flush}, 32'd1);
        cyc(); bus.dhit = 1'b0; #2;
        check("st_wen_after", {31'd0, bus.dmemWEN}, 32'd0);
        check("st_rdy_after", {31'd0, bus.ex_ready}, 32'd1);

        // ex_valid together with flush is ignored
        offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h44, 1'b0); bus.flush = 1'b1; #2;
        check("fl_ready", {31'd0, bus.ex_ready}, 32'd0);
        check("fl_mwf", {31'd0, bus.memwb_flush}, 32'd1);
        cyc(); idle(); bus.flush = 1'b0; #2;
        check("fl_no_entry", {31'd0, bus.memwb_EN}, 32'd0);

        // Load completing while the next ALU entry is accepted
        offer(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b0);
        cyc(); offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h66, 1'b0); bus.dhit = 1'b1; #2;
        check("b2b_wb_ld", {31'd0, bus.memwb_EN}, 32'd1);
        check("b2b_rdy", {31'd0, bus.ex_ready}, 32'd1);
        cyc(); idle(); bus.dhit = 1'b0; #2;
        check("b2b_wb_alu", {31'd0, bus.memwb_EN}, 32'd1);
        check("b2b_alu_val", bus.mem_alu_out, 32'h66);
        cyc();

`ifdef LL_SC_EN
        // LL, snoop invalidate, SC fails; then LL, SC succeeds
        offer(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 32'h0, 1'b0);
        cyc(); idle(); bus.dhit = 1'b1; #2;
        check("ll1_wb", {31'd0, bus.memwb_EN}, 32'd1);
        cyc(); bus.dhit = 1'b0; bus.ccinv = 1'b1; bus.ccsnoopaddr = 32'h200;
        cyc(); bus.ccinv = 1'b0;
        offer(1'b0, 1'b1, 1'b1, 32'h200, 32'hABCD, 32'h77, 1'b0);
        cyc(); idle(); #2;
        check("sc_fail_wen", {31'd0, bus.dmemWEN}, 32'd0);
        check("sc_fail_wb", {31'd0, bus.memwb_EN}, 32'd1);
        check("sc_fail_val", bus.mem_alu_out, 32'd0);
        cyc();
        offer(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 32'h0, 1'b0);
        cyc(); idle(); bus.dhit = 1'b1; #2;
        check("ll2_wb", {31'd0, bus.memwb_EN}, 32'd1);
        cyc(); bus.dhit = 1'b0;
        offer(1'b0, 1'b1, 1'b1, 32'h200, 32'hABCD, 32'h77, 1'b0);
        cyc(); idle(); #2;
        check("sc_ok_wen", {31'd0, bus.dmemWEN}, 32'd1);
        check("sc_ok_wait", {31'd0, bus.memwb_EN}, 32'd0);
        cyc(); bus.dhit = 1'b1; #2;
        check("sc_ok_wb", {31'd0, bus.memwb_EN}, 32'd1);
        check("sc_ok_val", bus.mem_alu_out, 32'd1);
        cyc(); bus.dhit = 1'b0;
`else
        // Without link tracking an SC is an ordinary store
        offer(1'b0, 1'b1, 1'b1, 32'h200, 32'hABCD, 32'h55, 1'b0);
        cyc(); idle(); bus.dhit = 1'b1; #2;
        check("sc_as_st_wen", {31'd0, bus.dmemWEN}, 32'd1);
        check("sc_as_st_wb", {31'd0, bus.memwb_EN}, 32'd1);
        check("sc_as_st_val", bus.mem_alu_out, 32'h55);
        cyc(); bus.dhit = 1'b0;
`endif

        // Reset while a load is pending
        offer(1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 32'h0, 1'b0);
        cyc(); idle(); #2;
        check("mid_ren", {31'd0, bus.dmemREN}, 32'd1);
        nRST = 1'b0; #1;
        check("mid_rst_ren", {31'd0, bus.dmemREN}, 32'd0);
        check("mid_rst_addr", bus.dmemaddr, 32'd0);
        check("mid_rst_wsel", bus.mem_wsel, 32'd0);
        check("mid_rst_wb", {31'd0, bus.memwb_EN}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.ex_ready}, 32'd0);
        cyc(); nRST = 1'b1; #2;
        check("mid_rel_ready", {31'd0, bus.ex_ready}, 32'd1);
        check("mid_rel_ren", {31'd0, bus.dmemREN}, 32'd0);

        // Halt entry: one write-back, then stalled for good
        offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h99, 1'b1);
        cyc(); idle(); #2;
        check("halt_wb", {31'd0, bus.memwb_EN}, 32'd1);
        check("halt_flag", {31'd0, bus.mem_halt}, 32'd1);
        check("halt_rdy0", {31'd0, bus.ex_ready}, 32'd0);
        offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hAA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(); #2;
            check("halted_rdy", {31'd0, bus.ex_ready}, 32'd0);
            check("halted_wb", {31'd0, bus.memwb_EN}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
